cpu_clk_ctrl: RTL and testbench
===============================

// Module: cpu_clk_ctrl
// PURPOSE
//   Run/step controller for the CPU clock enable. Consumes the 1 kHz (tick_fast) and 10 Hz (tick_slow) strobes
//   produced by the divider blocks and issues single-cycle cpu_en pulses to the core.
//   Modes: halt, debounced single-step from a board button, slow run and fast run.
//   Honours a halt request from the core and counts issued CPU cycles for the display.
// PARAMETERS
//   DEB_TICKS  20  consecutive tick_fast samples a button level must hold to be accepted (20 ms at 1 kHz)
//   CNT_W      32  width of cycle_cnt
// PORTS
//   CLK       in   1      system clock; all logic on posedge
//   RST       in   1      synchronous, active-high reset
//   tick_fast in   1      1-cycle strobe, 1 kHz
//   tick_slow in   1      1-cycle strobe, 10 Hz
//   mode      in   2      00 idle, 01 step, 10 run slow, 11 run fast (static or slowly changing)
//   step_btn  in   1      raw, asynchronous, bouncy push button (1 = pressed)
//   halt_req  in   1      level from core, 1 = stop issuing cycles
//   clr_cnt   in   1      1-cycle pulse, clears cycle_cnt
//   cpu_en    out  1      1-cycle clock-enable pulse to the CPU
//   state_o   out  3      current FSM state encoding (see below)
//   cycle_cnt out  CNT_W  number of cpu_en pulses issued, saturating
// BEHAVIOUR
//   Reset (RST=1 at posedge): cpu_en=0, state=IDLE, cycle_cnt=0; synchroniser flops, debounce counter
//     and debounced level are cleared to 0. Reset overrides every other input, including mid-debounce or mid-run.
//   FSM states (state_o): IDLE=0, STEP=1, RUN_S=2, RUN_F=3, HALTED=4.
//     - From IDLE/STEP/RUN_S/RUN_F with halt_req=0, the next state is decoded from mode:
//       00->IDLE, 01->STEP, 10->RUN_S, 11->RUN_F. A mode change takes effect at the next edge.
//     - From STEP/RUN_S/RUN_F with halt_req=1, the next state is HALTED.
//     - halt_req is ignored in IDLE.
//     - HALTED is left only when mode==00 (next state IDLE), regardless of halt_req.
//   cpu_en is registered and evaluated from the current (registered) state and this cycle's inputs:
//     - RUN_F: cpu_en <= tick_fast & ~halt_req
//     - RUN_S: cpu_en <= tick_slow & ~halt_req
//     - STEP:  cpu_en <= step_pulse & ~halt_req
//     - IDLE, HALTED: cpu_en <= 0
//     - Latency: the pulse appears one CLK after the qualifying strobe; it is never wider than 1 cycle.
//     - halt_req coincident with a strobe suppresses that pulse.
//   Debounce:
//     - step_btn passes through a 2-flop synchroniser (sync).
//     - deb_cnt only changes on cycles with tick_fast=1: cleared when sync==deb_lvl, else incremented.
//     - When deb_cnt==DEB_TICKS-1 and tick_fast=1 with sync!=deb_lvl: deb_lvl toggles and deb_cnt clears.
//     - step_pulse = 1-cycle pulse on each 0->1 transition of deb_lvl.
//     - Press-to-pulse latency: DEB_TICKS tick_fast periods plus up to 3 CLK.
//     - A step_pulse occurring outside STEP is discarded (never queued).
//   cycle_cnt:
//     - Increments by 1 on every cycle where cpu_en=1.
//     - Holds at 2^CNT_W-1 (no wrap).
//     - clr_cnt=1 clears it to 0; clear wins over a simultaneous increment.
//     - Not affected by mode or state changes.
// TESTING
//   1. DEB_TICKS=4; RST; mode=11; 5 tick_fast pulses 10 CLK apart
//      -> 5 cpu_en pulses, each exactly 1 CLK after its tick; cycle_cnt=5; state_o=3.
//   2. mode=01; step_btn toggles on 3 successive ticks, then held high for 6 ticks, then released for 6 ticks
//      -> exactly one cpu_en, on the 4th stable tick (+<=3 CLK); none on release; cycle_cnt=1.
//   3. mode=10; halt_req=1 on the same cycle as tick_slow
//      -> no cpu_en; state_o=4 next cycle.
//      Then halt_req=0 and 3 more ticks -> still no cpu_en.
//      Then mode=00 -> state_o=0.
//   4. CNT_W=4, mode=11, 20 tick_fast pulses
//      -> cycle_cnt reaches 15 and stays 15. Then clr_cnt -> 0.
//   5. clr_cnt asserted in the same cycle cpu_en=1 (cycle_cnt=7) -> cycle_cnt=0 the next cycle, not 1.
//   6. RST asserted mid-debounce (deb_cnt=2) while in RUN_F with cycle_cnt=9
//      -> next edge: cpu_en=0, state_o=0, cycle_cnt=0.
//      After release, the held button needs a full 4 ticks again before it is accepted.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// Run/step controller for the CPU clock enable: converts divider strobes or a
// debounced step button into single-cycle cpu_en pulses and counts them.
module cpu_clk_ctrl #(
    parameter int DEB_TICKS = 20,
    parameter int CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             tick_fast,
    input  logic             tick_slow,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    input  logic             halt_req,
    input  logic             clr_cnt,
    output logic             cpu_en,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STEP   = 3'd1,
        RUN_S  = 3'd2,
        RUN_F  = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t        state;
    state_t        mode_state;
    logic          sync_a;
    logic          sync_b;
    logic [DW-1:0] deb_cnt;
    logic          deb_lvl;
    logic          deb_lvl_q;
    logic          step_pulse;

    // Button synchroniser and tick-sampled debouncer; the level only flips after
    // DEB_TICKS consecutive tick samples disagree with it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            deb_cnt   <= {DW{1'b0}};
            deb_lvl   <= 1'b0;
            deb_lvl_q <= 1'b0;
        end else begin
            sync_a    <= step_btn;
            sync_b    <= sync_a;
            deb_lvl_q <= deb_lvl;
            if (tick_fast) begin
                if (sync_b == deb_lvl) begin
                    deb_cnt <= {DW{1'b0}};
                end else if (deb_cnt == DEB_LAST) begin
                    deb_lvl <= ~deb_lvl;
                    deb_cnt <= {DW{1'b0}};
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end
        end
    end

    assign step_pulse = deb_lvl & ~deb_lvl_q;

    // Mode select decode used by every non-halted state.
    always_comb begin
        mode_state = IDLE;
        case (mode)
            2'b00:   mode_state = IDLE;
            2'b01:   mode_state = STEP;
            2'b10:   mode_state = RUN_S;
            2'b11:   mode_state = RUN_F;
            default: mode_state = IDLE;
        endcase
    end

    // Run/step FSM with registered enable; the pulse qualifier uses the current state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cpu_en <= 1'b0;
        end else begin
            case (state)
                IDLE:               state <= mode_state;
                STEP, RUN_S, RUN_F: state <= halt_req ? HALTED : mode_state;
                HALTED:             state <= (mode == 2'b00) ? IDLE : HALTED;
                default:            state <= IDLE;
            endcase
            case (state)
                RUN_F:   cpu_en <= tick_fast  & ~halt_req;
                RUN_S:   cpu_en <= tick_slow  & ~halt_req;
                STEP:    cpu_en <= step_pulse & ~halt_req;
                default: cpu_en <= 1'b0;
            endcase
        end
    end

    assign state_o = state;

    // Saturating cycle counter; a clear beats a coincident increment.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_cnt <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            cycle_cnt <= {CNT_W{1'b0}};
        end else if (cpu_en && (cycle_cnt != CNT_MAX)) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end else begin
            cycle_cnt <= cycle_cnt;
        end
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed plus randomized bench for cpu_clk_ctrl, every cycle compared against
// a behavioural model of the mode/halt rules, debouncer and saturating counter.
module tb_cpu_clk_ctrl;

    localparam int DEB  = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          tf = 1'b0, ts = 1'b0, btn = 1'b0, halt = 1'b0, clr = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          cpu_en;
    logic [2:0]    state_o;
    logic [CW-1:0] cycle_cnt;

    int total = 0;
    int bad   = 0;
    int en_seen = 0;

    // model state
    int   m_state = 0, m_cnt = 0, m_deb = 0;
    logic m_en = 1'b0, m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0, m_lvlq = 1'b0;

    cpu_clk_ctrl #(.DEB_TICKS(DEB), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .tick_fast(tf), .tick_slow(ts), .mode(mode),
        .step_btn(btn), .halt_req(halt), .clr_cnt(clr),
        .cpu_en(cpu_en), .state_o(state_o), .cycle_cnt(cycle_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // 0 IDLE, 1 STEP, 2 RUN_S, 3 RUN_F, 4 HALTED
    function automatic int spec_next(input int cur, input logic [1:0] md, input logic h);
        if (cur == 4) return (md == 2'b00) ? 0 : 4;
        if (cur == 0 || !h) return int'(md);
        return 4;
    endfunction

    // One clock: drive strobes, predict, step, compare all outputs.
    task automatic cyc(input logic f, input logic s);
        int   ns, nc, nd;
        logic ne, nl, b;
        tf = f;
        ts = s;
        b  = btn;
        ne = 1'b0;
        if (!halt) begin
            if (m_state == 3) ne = f;
            else if (m_state == 2) ne = s;
            else if (m_state == 1) ne = m_lvl & ~m_lvlq;
            else ne = 1'b0;
        end
        nc = clr ? 0 : ((m_en && m_cnt < CMAX) ? m_cnt + 1 : m_cnt);
        ns = spec_next(m_state, mode, halt);
        nl = m_lvl;
        nd = m_deb;
        if (f) begin
            if (m_s2 == m_lvl) nd = 0;
            else if (m_deb == DEB - 1) begin nl = ~m_lvl; nd = 0; end
            else nd = m_deb + 1;
        end
        @(posedge CLK);
        #1;
        if (RST) begin
            m_state = 0; m_cnt = 0; m_deb = 0; m_en = 1'b0;
            m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_lvlq = 1'b0;
        end else begin
            m_s2 = m_s1; m_s1 = b; m_lvlq = m_lvl; m_lvl = nl; m_deb = nd;
            m_en = ne; m_cnt = nc; m_state = ns;
        end
        tf = 1'b0;
        ts = 1'b0;
        if (cpu_en === 1'b1) en_seen++;
        chk("cpu_en", 32'(cpu_en), 32'(m_en));
        chk("state_o", 32'(state_o), 32'(m_state));
        chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    task automatic fast_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0);
            idle(int'($urandom_range(3, 12)));
        end
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        cyc(1'b0, 1'b0);
        clr = 1'b0;
    endtask

    initial begin
        // reset
        idle(2);
        chk("rst_en", 32'(cpu_en), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_cnt", 32'(cycle_cnt), 32'd0);
        RST = 1'b0;

        // run fast: five ticks, five pulses
        mode = 2'b11;
        idle(1);
        en_seen = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0);
            chk("t1_pulse", 32'(cpu_en), 32'd1);
            idle(9);
        end
        chk("t1_pulses", 32'(en_seen), 32'd5);
        chk("t1_cnt", 32'(cycle_cnt), 32'd5);
        chk("t1_state", 32'(state_o), 32'd3);

        // step: bounce, hold, release
        mode = 2'b01;
        clear_pulse();
        en_seen = 0;
        for (int i = 0; i < 3; i++) begin
            btn = (i % 2 == 0);
            idle(3);
            cyc(1'b1, 1'b0);
        end
        btn = 1'b1;
        for (int i = 0; i < 6; i++) begin idle(4); cyc(1'b1, 1'b0); end
        idle(5);
        chk("t2_press_pulses", 32'(en_seen), 32'd1);
        btn = 1'b0;
        for (int i = 0; i < 6; i++) begin idle(4); cyc(1'b1, 1'b0); end
        idle(5);
        chk("t2_total_pulses", 32'(en_seen), 32'd1);
        chk("t2_cnt", 32'(cycle_cnt), 32'd1);

        // run slow with halt coincident with the strobe
        mode = 2'b10;
        idle(2);
        en_seen = 0;
        halt = 1'b1;
        cyc(1'b0, 1'b1);
        chk("t3_no_pulse", 32'(cpu_en), 32'd0);
        chk("t3_halted", 32'(state_o), 32'd4);
        halt = 1'b0;
        for (int i = 0; i < 3; i++) begin idle(5); cyc(1'b0, 1'b1); end
        idle(3);
        chk("t3_still_none", 32'(en_seen), 32'd0);
        mode = 2'b00;
        cyc(1'b0, 1'b0);
        chk("t3_idle", 32'(state_o), 32'd0);

        // saturation then clear
        mode = 2'b11;
        clear_pulse();
        fast_ticks(20);
        chk("t4_sat", 32'(cycle_cnt), 32'(CMAX));
        clear_pulse();
        chk("t4_clr", 32'(cycle_cnt), 32'd0);

        // clear beats a coincident increment
        fast_ticks(7);
        cyc(1'b1, 1'b0);
        chk("t5_pre", 32'(cycle_cnt), 32'd7);
        chk("t5_en", 32'(cpu_en), 32'd1);
        clear_pulse();
        chk("t5_clr_wins", 32'(cycle_cnt), 32'd0);
        idle(2);

        // reset mid-debounce in RUN_F
        clear_pulse();
        fast_ticks(7);
        btn = 1'b1;
        idle(3);
        fast_ticks(2);
        chk("t6_pre", 32'(cycle_cnt), 32'd9);
        RST = 1'b1;
        cyc(1'b0, 1'b0);
        chk("t6_en", 32'(cpu_en), 32'd0);
        chk("t6_state", 32'(state_o), 32'd0);
        chk("t6_cnt", 32'(cycle_cnt), 32'd0);
        RST = 1'b0;
        mode = 2'b01;
        idle(3);
        en_seen = 0;
        for (int i = 0; i < 3; i++) begin cyc(1'b1, 1'b0); idle(4); end
        chk("t6_not_yet", 32'(en_seen), 32'd0);
        cyc(1'b1, 1'b0);
        idle(4);
        chk("t6_accepted", 32'(en_seen), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            if ($urandom_range(0, 39) == 0) btn = ~btn;
            clr = ($urandom_range(0, 49) == 0);
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end
        clr  = 1'b0;
        halt = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
